// File: rtl/eth_rx_buf_pkg.sv
// eth_rx_buf_pkg: shared types and default widths for the rx store-and-forward buffer
package eth_rx_buf_pkg;
   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_MOD_WIDTH  = 3;
   typedef enum logic [1:0] {IDLE, RECV, DISCARD} rx_state_t;
   typedef struct packed {
      logic [DEF_DATA_WIDTH-1:0] data;
      logic [DEF_MOD_WIDTH-1:0]  mod;
      logic                      eop;
   } buf_word_t;
endpackage

// File: rtl/eth_pkt_if.sv
// eth_pkt_if: packet stream with val/sop/eop/mod framing and ready backpressure
interface eth_pkt_if #(
   parameter int DATA_WIDTH = 64,
   parameter int MOD_WIDTH  = 3,
   parameter int USER_WIDTH = 1
);
   logic                  val;
   logic                  sop;
   logic                  eop;
   logic [DATA_WIDTH-1:0] data;
   logic [MOD_WIDTH-1:0]  mod;
   logic [USER_WIDTH-1:0] tuser;
   logic                  ready;
   modport i (input val, sop, eop, data, mod, output ready);
   modport o (output val, sop, eop, data, mod, tuser, input ready);
endinterface

// File: rtl/eth_rx_buf_ram.sv
// eth_rx_buf_ram: simple dual-port RAM, one write port and one registered read port
module eth_rx_buf_ram
   import eth_rx_buf_pkg::*;
#(
   parameter int WIDTH = $bits(buf_word_t),
   parameter int DEPTH = 512,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   always_ff @(posedge clk_i)
      if (we_i) r_mem[waddr_i] <= wdata_i;
   // read register doubles as the output stage, so it holds when re_i is low
   always_ff @(posedge clk_i)
      if (rst_i) rdata_o <= '0;
      else if (re_i) rdata_o <= r_mem[raddr_i];
endmodule

// File: rtl/eth_rx_store_fwd_buf.sv
// eth_rx_store_fwd_buf: store-and-forward rx buffer that releases only complete packets.
// Optional ETH_RX_BUF_STATS_EN adds saturating committed-packet and drop counters.
module eth_rx_store_fwd_buf
   import eth_rx_buf_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int MOD_WIDTH     = DEF_MOD_WIDTH,
   parameter int DATA_DEPTH    = 512,
   parameter int MAX_PKT_WORDS = 256,
   localparam int PW           = $clog2(DATA_DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   eth_pkt_if.i          pkt_i,
   eth_pkt_if.o          pkt_o,
   input  logic          flush_i,
   output logic          drop_stb_o,
   output logic [PW-1:0] fill_words_o
`ifdef ETH_RX_BUF_STATS_EN
   ,
   output logic [31:0]   rx_pkt_cnt_o,
   output logic [31:0]   drop_cnt_o
`endif
);
   localparam int W  = DATA_WIDTH + MOD_WIDTH + 1;
   localparam int LW = $clog2(MAX_PKT_WORDS + 1);

   rx_state_t     r_state, w_state_n;
   logic [PW-1:0] r_wr, r_commit, r_rd, r_cnt, r_fill;
   logic [PW-1:0] w_wr_n, w_commit_n, w_rd_n, w_base, w_cnt_rem;
   logic [LW-1:0] r_len, w_len_n;
   logic          r_val, r_osop, r_arm, r_drop;
   logic          w_v, w_full, w_we, w_drop, w_commit, w_adv, w_last, w_arm, w_re;
   logic [W-1:0]  w_q;

   // a sop that truncates a packet is placed at the rolled-back write pointer
   assign w_v    = pkt_i.val & ~rst_i & ~flush_i;
   assign w_base = (r_state == RECV && pkt_i.sop) ? r_commit : r_wr;
   assign w_full = PW'(w_base - r_rd) == PW'(DATA_DEPTH);

   always_comb begin
      w_state_n = r_state;
      w_wr_n    = r_wr;
      w_len_n   = r_len;
      w_we      = 1'b0;
      w_drop    = 1'b0;
      w_commit  = 1'b0;
      if (w_v && pkt_i.sop) begin
         w_drop = r_state == RECV;
         if (w_full) begin
            w_drop    = 1'b1;
            w_wr_n    = w_base;
            w_state_n = pkt_i.eop ? IDLE : DISCARD;
         end else begin
            w_we      = 1'b1;
            w_wr_n    = w_base + PW'(1);
            w_len_n   = LW'(1);
            w_commit  = pkt_i.eop;
            w_state_n = pkt_i.eop ? IDLE : RECV;
         end
      end else if (w_v && r_state == RECV) begin
         if (w_full || r_len == LW'(MAX_PKT_WORDS)) begin
            w_drop    = 1'b1;
            w_wr_n    = r_commit;
            w_state_n = pkt_i.eop ? IDLE : DISCARD;
         end else begin
            w_we      = 1'b1;
            w_wr_n    = r_wr + PW'(1);
            w_len_n   = r_len + LW'(1);
            w_commit  = pkt_i.eop;
            w_state_n = pkt_i.eop ? IDLE : RECV;
         end
      end else if (w_v && r_state == DISCARD && pkt_i.eop) begin
         w_state_n = IDLE;
      end
      w_commit_n = w_commit ? w_wr_n : r_commit;
   end

   // fetch only while a committed, unsent packet remains beyond the word being handed off
   assign w_adv     = r_val & pkt_o.ready;
   assign w_last    = w_adv & w_q[0];
   assign w_rd_n    = r_rd + PW'(w_adv);
   assign w_cnt_rem = r_cnt - PW'(w_last);
   assign w_re      = (~r_val | pkt_o.ready) & (w_cnt_rem != '0);
   assign w_arm     = r_arm | w_last;

   eth_rx_buf_ram #(.WIDTH(W), .DEPTH(DATA_DEPTH)) u_ram (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (w_we),
      .waddr_i (w_base[PW-2:0]),
      .wdata_i ({pkt_i.data, pkt_i.mod, pkt_i.eop}),
      .re_i    (w_re),
      .raddr_i (w_rd_n[PW-2:0]),
      .rdata_o (w_q)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         r_state  <= IDLE;
         r_wr     <= '0;
         r_commit <= '0;
         r_rd     <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         r_val    <= 1'b0;
         r_arm    <= 1'b1;
         r_drop   <= 1'b0;
         r_fill   <= '0;
      end else begin
         r_state  <= w_state_n;
         r_wr     <= w_wr_n;
         r_commit <= w_commit_n;
         r_rd     <= w_rd_n;
         r_len    <= w_len_n;
         r_cnt    <= w_cnt_rem + PW'(w_commit);
         r_val    <= w_re | (r_val & ~pkt_o.ready);
         r_arm    <= ~w_re & w_arm;
         r_drop   <= w_drop;
         r_fill   <= w_wr_n - w_rd_n;
      end
   end

   always_ff @(posedge clk_i)
      if (rst_i) r_osop <= 1'b0;
      else if (w_re) r_osop <= w_arm;

`ifdef ETH_RX_BUF_STATS_EN
   logic [31:0] r_rx_cnt, r_drop_cnt;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rx_cnt   <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_commit && ~&r_rx_cnt) r_rx_cnt <= r_rx_cnt + 32'd1;
         if (r_drop && ~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + 32'd1;
      end
   end
   assign rx_pkt_cnt_o = r_rx_cnt;
   assign drop_cnt_o   = r_drop_cnt;
`endif

   assign pkt_i.ready  = 1'b1;
   assign pkt_o.val    = r_val;
   assign pkt_o.sop    = r_osop;
   assign pkt_o.data   = w_q[W-1 -: DATA_WIDTH];
   assign pkt_o.mod    = w_q[MOD_WIDTH:1];
   assign pkt_o.eop    = w_q[0];
   assign pkt_o.tuser  = '0;
   assign drop_stb_o   = r_drop;
   assign fill_words_o = r_fill;
endmodule

// File: tb/tb_eth_rx_store_fwd_buf.sv
// tb_eth_rx_store_fwd_buf: directed bench for the rx store-and-forward buffer (16-word depth, 12-word max packet)
module tb_eth_rx_store_fwd_buf;
   localparam int DEPTH = 16;
   localparam int MAXW  = 12;
   localparam int PW    = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic drop;
   logic [PW-1:0] fill;
`ifdef ETH_RX_BUF_STATS_EN
   logic [31:0] rxc, dc;
`endif

   eth_pkt_if #(.DATA_WIDTH(64), .MOD_WIDTH(3)) in_if ();
   eth_pkt_if #(.DATA_WIDTH(64), .MOD_WIDTH(3)) out_if ();

   eth_rx_store_fwd_buf #(.DATA_DEPTH(DEPTH), .MAX_PKT_WORDS(MAXW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .pkt_i        (in_if),
      .pkt_o        (out_if),
      .flush_i      (flush),
      .drop_stb_o   (drop),
      .fill_words_o (fill)
`ifdef ETH_RX_BUF_STATS_EN
      ,
      .rx_pkt_cnt_o (rxc),
      .drop_cnt_o   (dc)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] d;
      logic        s;
      logic        e;
      logic [2:0]  m;
   } cap_t;

   int vecs = 0;
   int miss = 0;
   int drops = 0;
   cap_t cap[$];
   logic stalled = 1'b0;
   logic [63:0] held = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (stalled && out_if.val) chk("stall_hold", out_if.data, held);
      stalled = out_if.val && !out_if.ready;
      held = out_if.data;
      if (out_if.val && out_if.ready) cap.push_back({out_if.data, out_if.sop, out_if.eop, out_if.mod});
      if (drop) drops++;
   end

   task automatic send(input logic [63:0] d, input logic s, input logic e, input logic [2:0] m);
      in_if.val = 1'b1; in_if.sop = s; in_if.eop = e; in_if.data = d; in_if.mod = m;
      @(posedge clk); #1;
      in_if.val = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_caps(input int n, input string tag);
      int k = 0;
      while (cap.size() < n && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 64'(cap.size()), 64'(n));
   endtask

   task automatic chk_word(input int i, input logic [63:0] d, input logic s, input logic e, input logic [2:0] m);
      cap_t c;
      c = (i < cap.size()) ? cap[i] : '0;
      chk($sformatf("word%0d_data", i), c.d, d);
      chk($sformatf("word%0d_sop_eop_mod", i), {59'd0, c.s, c.e, c.m}, {59'd0, s, e, m});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      in_if.val = 1'b1; in_if.sop = 1'b1; in_if.eop = 1'b1;
      in_if.data = 64'hdead; in_if.mod = 3'd0; in_if.tuser = '0;
      out_if.ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_val", out_if.val, 0);
      chk("rst_sop", out_if.sop, 0);
      chk("rst_eop", out_if.eop, 0);
      chk("rst_data", out_if.data, 0);
      chk("rst_mod", out_if.mod, 0);
      chk("rst_drop", drop, 0);
      chk("rst_fill", fill, 0);
      chk("rst_in_ready", in_if.ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      in_if.val = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0;
      idle(3);
      @(negedge clk);
      chk("post_rst_fill", fill, 0);
      chk("post_rst_val", out_if.val, 0);

      // 1: 3-word packet, 2-cycle latency after eop
      drops = 0; cap.delete();
      send(64'h1111_0000_0000_0001, 1, 0, 0);
      send(64'h1111_0000_0000_0002, 0, 0, 0);
      send(64'h1111_0000_0000_0003, 0, 1, 5);
      @(negedge clk);
      chk("t1_val_eop_plus1", out_if.val, 0);
      @(negedge clk);
      chk("t1_val_eop_plus2", out_if.val, 1);
      chk("t1_first_sop", out_if.sop, 1);
      chk("t1_first_data", out_if.data, 64'h1111_0000_0000_0001);
      wait_caps(3, "t1_count");
      chk_word(0, 64'h1111_0000_0000_0001, 1, 0, 0);
      chk_word(1, 64'h1111_0000_0000_0002, 0, 0, 0);
      chk_word(2, 64'h1111_0000_0000_0003, 0, 1, 5);
      chk("t1_drops", 64'(drops), 0);

      // 2: ten single-word packets with ready toggling
      drops = 0; cap.delete();
      for (int i = 0; i < 10; i++) begin
         out_if.ready = i[0];
         send(64'h200 + 64'(i), 1, 1, i[2:0]);
      end
      for (int k = 0; k < 200 && cap.size() < 10; k++) begin
         out_if.ready = ~out_if.ready;
         @(posedge clk); #1;
      end
      out_if.ready = 1'b1;
      chk("t2_count", 64'(cap.size()), 10);
      for (int i = 0; i < 10; i++) chk_word(i, 64'h200 + 64'(i), 1, 1, i[2:0]);
      chk("t2_drops", 64'(drops), 0);

      // 3: stalled sink, 12-word packet kept, 8-word packet overflows
      drops = 0; cap.delete();
      out_if.ready = 1'b0;
      for (int i = 0; i < 12; i++) send(64'h300 + 64'(i), i == 0, i == 11, 0);
      for (int i = 0; i < 8; i++) send(64'h400 + 64'(i), i == 0, i == 7, 0);
      idle(2);
      @(negedge clk);
      chk("t3_drops", 64'(drops), 1);
      chk("t3_fill", fill, 12);
      chk("t3_hold_val", out_if.val, 1);
      chk("t3_hold_data", out_if.data, 64'h300);
      chk("t3_hold_sop", out_if.sop, 1);
      out_if.ready = 1'b1;
      wait_caps(12, "t3_count");
      chk_word(0, 64'h300, 1, 0, 0);
      chk_word(11, 64'h30b, 0, 1, 0);
      idle(2);
      @(negedge clk);
      chk("t3_fill_drained", fill, 0);
      chk("t3_drops_final", 64'(drops), 1);

      // 4: over-length packet dropped, following packet delivered
      drops = 0; cap.delete();
      for (int i = 0; i < 13; i++) send(64'h500 + 64'(i), i == 0, i == 12, 0);
      send(64'h600, 1, 0, 0);
      send(64'h601, 0, 1, 2);
      wait_caps(2, "t4_count");
      idle(4);
      chk("t4_count_final", 64'(cap.size()), 2);
      chk_word(0, 64'h600, 1, 0, 0);
      chk_word(1, 64'h601, 0, 1, 2);
      chk("t4_drops", 64'(drops), 1);

      // 5: truncated packet, then orphan word in IDLE
      drops = 0; cap.delete();
      send(64'h700, 1, 0, 0);
      send(64'h701, 0, 0, 0);
      send(64'h800, 1, 0, 0);
      send(64'h801, 0, 0, 0);
      send(64'h802, 0, 1, 7);
      send(64'h900, 0, 1, 3);
      wait_caps(3, "t5_count");
      idle(4);
      chk("t5_count_final", 64'(cap.size()), 3);
      chk_word(0, 64'h800, 1, 0, 0);
      chk_word(1, 64'h801, 0, 0, 0);
      chk_word(2, 64'h802, 0, 1, 7);
      chk("t5_drops", 64'(drops), 1);
      @(negedge clk);
      chk("t5_fill", fill, 0);

      // 6: flush mid-input, then mid-output
      drops = 0; cap.delete();
      send(64'hA00, 1, 0, 0);
      send(64'hA01, 0, 0, 0);
      in_if.val = 1'b1; in_if.eop = 1'b1; in_if.data = 64'hA02;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_if.val = 1'b0; in_if.eop = 1'b0;
      @(negedge clk);
      chk("t6a_fill", fill, 0);
      chk("t6a_val", out_if.val, 0);
      out_if.ready = 1'b0;
      send(64'hB00, 1, 0, 0);
      send(64'hB01, 0, 0, 0);
      send(64'hB02, 0, 1, 1);
      idle(2);
      out_if.ready = 1'b1;
      @(posedge clk); #1;
      out_if.ready = 1'b0;
      chk("t6b_word0_taken", 64'(cap.size()), 1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("t6b_val", out_if.val, 0);
      chk("t6b_fill", fill, 0);
      cap.delete();
      out_if.ready = 1'b1;
      send(64'hC00, 1, 0, 0);
      send(64'hC01, 0, 1, 4);
      wait_caps(2, "t6_count");
      idle(4);
      chk("t6_count_final", 64'(cap.size()), 2);
      chk_word(0, 64'hC00, 1, 0, 0);
      chk_word(1, 64'hC01, 0, 1, 4);
      chk("t6_drops", 64'(drops), 0);
`ifdef ETH_RX_BUF_STATS_EN
      chk("stats_rx_pkt_cnt", rxc, 16);
      chk("stats_drop_cnt", dc, 3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
